seq_detect: RTL and testbench

SEQ_DETECT -- requirements
Module: seq_detect

---
 rtl/seq_detect_if.sv | 29 ++
 rtl/seq_detect.sv | 99 +++++++++
 tb/tb_seq_detect.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seq_detect_if.sv
// seq_detect_if: bundles the serial data/control inputs and the status
// outputs of seq_detect.
//   master modport (stimulus side): drives din, din_valid, clr; observes
//                                   det, state, match_cnt, gap_cnt, last_gap
//   slave modport  (detector side): the mirror image
// CNT_W sets the width of the three counters and must match the CNT_W of
// the seq_detect instance it connects to.
interface seq_detect_if #(
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_valid;
    logic             clr;
    logic             det;
    logic [1:0]       state;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] last_gap;

    modport master (
        output din, din_valid, clr,
        input  det, state, match_cnt, gap_cnt, last_gap
    );

    modport slave (
        input  din, din_valid, clr,
        output det, state, match_cnt, gap_cnt, last_gap
    );
endinterface

// File: rtl/seq_detect.sv
// seq_detect: overlapping detector for the serial pattern 1101.
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   bus.din / bus.din_valid  one data bit consumed per edge with din_valid=1
//   bus.clr   synchronous clear of the three counters (not FSM, not det)
//   bus.det   registered one-cycle pulse after the bit completing 1101
//   bus.state registered FSM state (00 none, 01 "1", 10 "11", 11 "110")
//   bus.match_cnt  detections since reset/clr, saturating
//   bus.gap_cnt    valid bits since last detection, saturating
//   bus.last_gap   gap_cnt+1 captured at the latest detection, saturating
module seq_detect #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_detect_if.slave  bus
);
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic             det_reg, det_next;
    logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
    logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [CNT_W-1:0] last_gap_reg, last_gap_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S0;
            det_reg       <= 1'b0;
            match_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
            last_gap_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            det_reg       <= det_next;
            match_cnt_reg <= match_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            last_gap_reg  <= last_gap_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        det_next       = 1'b0;
        match_cnt_next = match_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        last_gap_next  = last_gap_reg;

        if (bus.din_valid) begin
            unique case (state_reg)
                S0: state_next = bus.din ? S1 : S0;
                S1: state_next = bus.din ? S2 : S0;
                S2: state_next = bus.din ? S2 : S3;
                S3: begin
                    // The completing 1 doubles as the "1" prefix of the
                    // next pattern, which gives overlapping detection.
                    state_next = bus.din ? S1 : S0;
                    det_next   = bus.din;
                end
                default: state_next = S0;
            endcase

            if (det_next) begin
                match_cnt_next = sat_inc(match_cnt_reg);
                // The completing bit is counted in the captured gap.
                last_gap_next  = sat_inc(gap_cnt_reg);
                gap_cnt_next   = '0;
            end else begin
                gap_cnt_next   = sat_inc(gap_cnt_reg);
            end
        end

        // Clear wins over any counter update but leaves FSM and det alone,
        // so a detection on the clearing edge still pulses det.
        if (bus.clr) begin
            match_cnt_next = '0;
            gap_cnt_next   = '0;
            last_gap_next  = '0;
        end
    end

    assign bus.det       = det_reg;
    assign bus.state     = state_reg;
    assign bus.match_cnt = match_cnt_reg;
    assign bus.gap_cnt   = gap_cnt_reg;
    assign bus.last_gap  = last_gap_reg;
endmodule

// File: tb/tb_seq_detect.sv
// tb_seq_detect: directed, table-driven bench for seq_detect (CNT_W=8).
module tb_seq_detect;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seq_detect_if #(.CNT_W(CNT_W)) bus ();

    seq_detect #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       din;
        logic       vld;
        logic       clr;
        logic [1:0] st;
        logic       det;
        int         mcnt;
        int         gcnt;
        int         lgap;
    } vec_t;

    vec_t vecs[30];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs, clock one edge, leave time 1 unit after the edge.
    task automatic step(input logic d, input logic v, input logic c);
        bus.din       = d;
        bus.din_valid = v;
        bus.clr       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic d,
                             input int m, input int g, input int l);
        check({tag, " state"},     int'(bus.state),     int'(st));
        check({tag, " det"},       int'(bus.det),       int'(d));
        check({tag, " match_cnt"}, int'(bus.match_cnt), m);
        check({tag, " gap_cnt"},   int'(bus.gap_cnt),   g);
        check({tag, " last_gap"},  int'(bus.last_gap),  l);
        $display("%s: state=%b det=%b match=%0d gap=%0d last=%0d", tag,
                 bus.state, bus.det, bus.match_cnt, bus.gap_cnt, bus.last_gap);
    endtask

    task automatic do_reset();
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        //            din vld clr  st    det mcnt gcnt lgap
        vecs[0]  = '{1'b1,1'b1,1'b0,2'b01,1'b0,0,1,0};
        vecs[1]  = '{1'b1,1'b1,1'b0,2'b10,1'b0,0,2,0};
        vecs[2]  = '{1'b0,1'b1,1'b0,2'b11,1'b0,0,3,0};
        vecs[3]  = '{1'b1,1'b1,1'b0,2'b01,1'b1,1,0,4};
        vecs[4]  = '{1'b1,1'b1,1'b0,2'b10,1'b0,1,1,4};
        vecs[5]  = '{1'b0,1'b1,1'b0,2'b11,1'b0,1,2,4};
        vecs[6]  = '{1'b1,1'b1,1'b0,2'b01,1'b1,2,0,3};
        vecs[7]  = '{1'b1,1'b1,1'b0,2'b10,1'b0,2,1,3};
        vecs[8]  = '{1'b0,1'b1,1'b0,2'b11,1'b0,2,2,3};
        vecs[9]  = '{1'b1,1'b0,1'b0,2'b11,1'b0,2,2,3};
        vecs[10] = '{1'b1,1'b0,1'b0,2'b11,1'b0,2,2,3};
        vecs[11] = '{1'b1,1'b0,1'b0,2'b11,1'b0,2,2,3};
        vecs[12] = '{1'b1,1'b0,1'b0,2'b11,1'b0,2,2,3};
        vecs[13] = '{1'b1,1'b0,1'b0,2'b11,1'b0,2,2,3};
        vecs[14] = '{1'b1,1'b1,1'b0,2'b01,1'b1,3,0,3};
        vecs[15] = '{1'b0,1'b1,1'b0,2'b00,1'b0,3,1,3};
        vecs[16] = '{1'b0,1'b0,1'b1,2'b00,1'b0,0,0,0};
        vecs[17] = '{1'b1,1'b1,1'b0,2'b01,1'b0,0,1,0};
        vecs[18] = '{1'b1,1'b1,1'b0,2'b10,1'b0,0,2,0};
        vecs[19] = '{1'b0,1'b1,1'b0,2'b11,1'b0,0,3,0};
        vecs[20] = '{1'b1,1'b1,1'b1,2'b01,1'b1,0,0,0};
        vecs[21] = '{1'b0,1'b1,1'b0,2'b00,1'b0,0,1,0};
        vecs[22] = '{1'b1,1'b1,1'b0,2'b01,1'b0,0,2,0};
        vecs[23] = '{1'b0,1'b1,1'b0,2'b00,1'b0,0,3,0};
        vecs[24] = '{1'b1,1'b1,1'b0,2'b01,1'b0,0,4,0};
        vecs[25] = '{1'b1,1'b1,1'b0,2'b10,1'b0,0,5,0};
        vecs[26] = '{1'b1,1'b1,1'b0,2'b10,1'b0,0,6,0};
        vecs[27] = '{1'b0,1'b1,1'b0,2'b11,1'b0,0,7,0};
        vecs[28] = '{1'b0,1'b1,1'b0,2'b00,1'b0,0,8,0};
        vecs[29] = '{1'b0,1'b1,1'b0,2'b00,1'b0,0,9,0};

        // Reset is applied at time zero, before any clock edge.
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr = 1'b0;
        rst = 1'b1;
        #1;
        check_all("reset", 2'b00, 1'b0, 0, 0, 0);
        do_reset();

        for (int i = 0; i < 30; i++) begin
            step(vecs[i].din, vecs[i].vld, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].det,
                      vecs[i].mcnt, vecs[i].gcnt, vecs[i].lgap);
        end

        // Asynchronous reset between edges after a 110 prefix.
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_all("prefix110", 2'b11, 1'b0, 0, 3, 0);
        bus.din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 2'b00, 1'b0, 0, 0, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0);
        check_all("post_rst_1", 2'b01, 1'b0, 0, 1, 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_all("post_rst_full", 2'b01, 1'b1, 1, 0, 4);
        step(1'b0, 1'b0, 1'b0);
        check_all("det_drop", 2'b01, 1'b0, 1, 0, 4);

        // Saturation of match_cnt with repeated 1101.
        do_reset();
        for (int p = 0; p < 300; p++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            if (p == 254 || p == 255 || p == 299)
                check_all($sformatf("sat_p%0d", p), 2'b01, 1'b1,
                          (p < 255) ? p + 1 : 255, 0, 4);
        end

        // Saturation of gap_cnt with zeros.
        do_reset();
        for (int z = 0; z < 300; z++) step(1'b0, 1'b1, 1'b0);
        check_all("gap_sat", 2'b00, 1'b0, 0, 255, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
